// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the div48by24 restoring divider
// Contents: FSM state type, default widths, counter width, divide-by-zero quotient.
package div_pkg;

  localparam int DW_DEF = 48;
  localparam int VW_DEF = 24;
  localparam int CNT_W  = $clog2(DW_DEF);

  // Quotient reported on divide-by-zero; sliced down to the datapath width.
  localparam logic [63:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/div_lzc8.sv
// rtl/div_lzc8.sv - byte-granular leading-zero counter for the divider skip path
// Ports:
//   data  in   DW   value to scan, MSB byte first
//   lz8   out  LZW  number of all-zero leading bytes (DW/8 when data is zero)
module div_lzc8 #(
  parameter int DW  = 48,
  parameter int LZW = $clog2(DW / 8 + 1)
) (
  input  logic [DW-1:0]  data,
  output logic [LZW-1:0] lz8
);

  logic found;

  always_comb begin
    lz8   = '0;
    found = 1'b0;
    for (int g = DW / 8 - 1; g >= 0; g--) begin
      if (!found) begin
        if (data[g*8 +: 8] == 8'h00) begin
          lz8 = lz8 + LZW'(1);
        end else begin
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/div48by24.sv
// rtl/div48by24.sv - sequential restoring divider, one quotient bit per clock
// Optional build macro: DIV_LZ_SKIP_EN (pre-shifts away leading zero bytes of the dividend).
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   synchronous active-low reset
//   start        in   1   request, sampled only in IDLE
//   dividend     in   DW  captured on accept
//   divisor      in   VW  captured on accept
//   busy         out  1   operation in flight
//   out_valid    out  1   one-cycle result pulse, results held afterwards
//   quotient     out  DW  result
//   remainder    out  VW  result
//   div_by_zero  out  1   divisor was zero for the reported result
module div48by24
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW == DW_DEF) ? CNT_W : $clog2(DW);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // Dividend shifts out of the top while quotient bits fill the vacated bottom.
  logic [DW-1:0] sreg_q, sreg_d;
  // Partial remainder is always < divisor, so VW bits hold it between cycles;
  // only the shifted trial value needs the extra bit.
  logic [VW-1:0] pr_q, pr_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic [VW:0]   pr_shift;

`ifdef DIV_LZ_SKIP_EN
  localparam int NG  = DW / 8;
  localparam int LZW = $clog2(NG + 1);
  logic [LZW-1:0] lz8;

  div_lzc8 #(
    .DW  (DW),
    .LZW (LZW)
  ) u_lzc (
    .data (dividend),
    .lz8  (lz8)
  );
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sreg_d      = sreg_q;
    pr_d        = pr_q;
    divisor_d   = divisor_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    pr_shift    = {pr_q, sreg_q[DW-1]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          divisor_d = divisor;
          sreg_d    = dividend;
          pr_d      = '0;
          count_d   = CW'(DW - 1);
          busy_d    = 1'b1;
          if (divisor == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef DIV_LZ_SKIP_EN
            if (int'(lz8) == NG) begin
              // Zero dividend: sreg and pr are already the 0/0 result.
              state_d = S_DONE;
            end else begin
              sreg_d  = dividend << (8 * int'(lz8));
              count_d = CW'(DW - 1 - 8 * int'(lz8));
              state_d = S_DIVIDE;
            end
`else
            state_d = S_DIVIDE;
`endif
          end
        end
      end

      S_DIVIDE: begin
        if (pr_shift >= {1'b0, divisor_q}) begin
          pr_d   = VW'(pr_shift - {1'b0, divisor_q});
          sreg_d = {sreg_q[DW-2:0], 1'b1};
        end else begin
          pr_d   = pr_shift[VW-1:0];
          sreg_d = {sreg_q[DW-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
        // A zero divisor skipped DIVIDE, so sreg still holds the raw dividend.
        if (divisor_q == '0) begin
          quotient_d  = DZ_QUOT[DW-1:0];
          remainder_d = sreg_q[VW-1:0];
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = sreg_q;
          remainder_d = pr_q;
          dbz_d       = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      sreg_q      <= '0;
      pr_q        <= '0;
      divisor_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sreg_q      <= sreg_d;
      pr_q        <= pr_d;
      divisor_q   <= divisor_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div48by24.sv
// tb/tb_div48by24.sv - self-checking bench for div48by24
module tb_div48by24;

  localparam int DW = 48;
  localparam int VW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div48by24 #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division per the documented rules.
  task automatic model(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                       output logic [DW-1:0] q, output logic [VW-1:0] r, output logic dz);
    longint unsigned a, b;
    a = 64'(dvd);
    b = 64'(dvs);
    if (b == 0) begin
      q  = '1;
      r  = dvd[VW-1:0];
      dz = 1'b1;
    end else begin
      q  = DW'(a / b);
      r  = VW'(a % b);
      dz = 1'b0;
    end
  endtask

  // Rising edges from the accept edge to the edge after which out_valid is high.
  function automatic int exp_lat(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
    int bl;
    if (dvs == '0) return 1;
`ifdef DIV_LZ_SKIP_EN
    if (dvd == '0) return 1;
    bl = 0;
    for (int i = 0; i < DW; i++) if (dvd[i]) bl = i + 1;
    return DW - 8 * ((DW - bl) / 8) + 1;
`else
    bl = int'(dvd[0]);
    return DW + 1 + (bl - bl);
`endif
  endfunction

  // Launch one divide and check it. inject pulses extra starts at wait cycles 5 and 20.
  task automatic do_div(input string name, input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz,
                        input bit inject);
    int  edges;
    bit  seen;
    bit  busy_drop;
    int  pulses;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check({name, ".busy_after_accept"}, 64'(busy), 64'(1));
    edges = 0;
    seen = 1'b0;
    busy_drop = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_drop = 1'b1;
        if (inject && (edges == 5 || edges == 20)) begin
          start    = 1'b1;
          dividend = 48'h111111111111;
          divisor  = 24'h000003;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: no out_valid within %0d cycles", name, edges);
      return;
    end
    check({name, ".latency"}, 64'(edges), 64'(exp_lat(dvd, dvs)));
    check({name, ".busy_held"}, 64'(busy_drop), 64'(0));
    check({name, ".busy_at_valid"}, 64'(busy), 64'(0));
    check({name, ".quotient"}, 64'(quotient), 64'(eq));
    check({name, ".remainder"}, 64'(remainder), 64'(er));
    check({name, ".div_by_zero"}, 64'(div_by_zero), 64'(edz));
    if (inject) begin
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
      end
      check({name, ".extra_valid"}, 64'(pulses), 64'(0));
      check({name, ".idle_busy"}, 64'(busy), 64'(0));
      check({name, ".held_quotient"}, 64'(quotient), 64'(eq));
    end
  endtask

  initial begin
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    int            pulses;

    vecs[0] = '{48'h00E100000000, 24'h0F0000, 48'h0000000F0000, 24'h000000, 1'b0};
    vecs[1] = '{48'h004000000000, 24'h080000, 48'h000000080000, 24'h000000, 1'b0};
    vecs[2] = '{48'h000400000007, 24'h020000, 48'h000000020000, 24'h000007, 1'b0};
    vecs[3] = '{48'h123456789ABC, 24'h000000, 48'hFFFFFFFFFFFF, 24'h789ABC, 1'b1};
    vecs[4] = '{48'h00000000000A, 24'h000003, 48'h000000000003, 24'h000001, 1'b0};
    vecs[5] = '{48'h0000000000FF, 24'h000010, 48'h00000000000F, 24'h00000F, 1'b0};
    vecs[6] = '{48'h000000000000, 24'h000005, 48'h000000000000, 24'h000000, 1'b0};
    vecs[7] = '{48'hFFFFFFFFFFFF, 24'h000001, 48'hFFFFFFFFFFFF, 24'h000000, 1'b0};
    vecs[8] = '{48'hFFFFFFFFFFFF, 24'hFFFFFF, 48'h000001000001, 24'h000000, 1'b0};
    vecs[9] = '{48'h000000000005, 24'h000007, 48'h000000000000, 24'h000005, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.quotient", 64'(quotient), 64'(0));
    check("reset.remainder", 64'(remainder), 64'(0));
    check("reset.div_by_zero", 64'(div_by_zero), 64'(0));

    // Back-to-back table: each start goes in during the previous out_valid cycle.
    for (int i = 0; i < 10; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
             vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
    end

    // Starts during an operation are dropped, not queued.
    do_div("ignore", vecs[0].dvd, vecs[0].dvs, vecs[0].q, vecs[0].r, vecs[0].dz, 1'b1);

    // Reset in the middle of DIVIDE aborts with no result pulse.
    dividend = vecs[0].dvd;
    divisor  = vecs[0].dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset.busy", 64'(busy), 64'(0));
    check("midreset.quotient", 64'(quotient), 64'(0));
    check("midreset.out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("midreset.no_valid", 64'(pulses), 64'(0));
    do_div("after_reset", vecs[4].dvd, vecs[4].dvs, vecs[4].q, vecs[4].r, vecs[4].dz, 1'b0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      dvd = DW'({$urandom, $urandom}) >> $urandom_range(0, 47);
      dvs = VW'($urandom) >> $urandom_range(0, 23);
      if ($urandom_range(0, 7) == 0) dvs = '0;
      if ($urandom_range(0, 15) == 0) dvd = '0;
      model(dvd, dvs, q, r, dz);
      do_div($sformatf("rand%0d", i), dvd, dvs, q, r, dz, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
